// File: rtl/alu_pkg.sv
// alu_pkg: shared alu control words ({zx,nx,zy,ny,f,no} bit order) and multiplier FSM states.
package alu_pkg;
  localparam logic [5:0] ALU_CTL_ADD  = 6'b000010;
  localparam logic [5:0] ALU_CTL_ZERO = 6'b101010;
  localparam logic [5:0] ALU_CTL_ZY   = 6'b001000;
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DBL, S_DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: start/done request bus between the CPU side and the multiplier.
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [15:0] product;
  logic        zr;
  logic        ng;
  modport master (output start, a, b, input ready, done, product, zr, ng);
  modport slave (input start, a, b, output ready, done, product, zr, ng);
endinterface

// File: rtl/alu_mul_seq_alu.sv
// alu: combinational Hack-style 16-bit alu driven by {zx,nx,zy,ny,f,no}.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] xz, xn, yz, yn, fo;
  always_comb begin
    xz  = zx ? 16'h0 : x;
    xn  = nx ? ~xz : xz;
    yz  = zy ? 16'h0 : y;
    yn  = ny ? ~yz : yz;
    fo  = f ? xn + yn : xn & yn;
    out = no ? ~fo : fo;
    zr  = out == 16'h0;
    ng  = out[15];
  end
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16x16 -> 16 multiplier sequencing a private alu.
// Define MUL_EARLY_EXIT_EN to skip zero multiplier bits and stop once the multiplier is exhausted.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     bus
);
  mul_state_t state, nxt;
  logic [W-1:0] acc, mcand, mplier, x, y, out, product;
  logic [3:0] cnt;
  logic [5:0] ctl;
  logic done, zr, ng, alu_zr, alu_ng, last;
  assign last = cnt == 4'(ITERS - 1);
  // DONE reuses the alu as a pass-through (acc + 0) so its zr/ng flags register with product
  always_comb begin
    x   = state == S_DBL ? mcand : acc;
    y   = mcand;
    ctl = state == S_ADD  ? (mplier[0] ? ALU_CTL_ADD : ALU_CTL_ADD | ALU_CTL_ZY) :
          state == S_DBL  ? ALU_CTL_ADD :
          state == S_DONE ? ALU_CTL_ADD | ALU_CTL_ZY : ALU_CTL_ZERO;
  end
  alu u_alu (
    .x(x), .y(y),
    .zx(ctl[5]), .nx(ctl[4]), .zy(ctl[3]), .ny(ctl[2]), .f(ctl[1]), .no(ctl[0]),
    .out(out), .zr(alu_zr), .ng(alu_ng)
  );
  always_comb begin
    nxt = state;
    unique case (state)
`ifdef MUL_EARLY_EXIT_EN
      S_IDLE: nxt = !bus.start ? S_IDLE : bus.b == '0 ? S_DONE : bus.b[0] ? S_ADD : S_DBL;
      S_DBL:  nxt = (mplier[W-1:1] == '0 || last) ? S_DONE : mplier[1] ? S_ADD : S_DBL;
`else
      S_IDLE: nxt = bus.start ? S_ADD : S_IDLE;
      S_DBL:  nxt = last ? S_DONE : S_ADD;
`endif
      S_ADD:  nxt = S_DBL;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      zr      <= 1'b1;
      ng      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nxt;
      done  <= state == S_DONE;
      unique case (state)
        S_IDLE: if (bus.start) begin
          acc    <= '0;
          mcand  <= bus.a;
          mplier <= bus.b;
          cnt    <= '0;
        end
        S_ADD: acc <= out;
        S_DBL: begin
          mcand  <= out;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        S_DONE: begin
          product <= out;
          zr      <= alu_zr;
          ng      <= alu_ng;
        end
        default: ;
      endcase
    end
  end
  assign bus.ready   = state == S_IDLE;
  assign bus.done    = done;
  assign bus.product = product;
  assign bus.zr      = zr;
  assign bus.ng      = ng;
endmodule
